// File: rtl/pio_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single PIO slave.
// Each access runs IDLE -> ACCESS -> DONE -> IDLE: one chipselect cycle, then one ack cycle.
module pio_access_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_readdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_readdata,

    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,

    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              chipselect_q, chipselect_d;
    logic              write_n_q, write_n_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic              last_grant_q, last_grant_d;

    // Next-state and registered-output computation; the address/writedata registers double as
    // the latch of the granted request, so they simply hold outside a new grant.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        chipselect_d = 1'b0;
        write_n_d    = 1'b1;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        last_grant_d = last_grant_q;

        unique case (state_q)
            StIdle: begin
                if (r0_req || r1_req) begin
                    // On a tie, the requester that did not win last time goes next.
                    gnt_d        = (r0_req && r1_req) ? ~last_grant_q : r1_req;
                    we_d         = gnt_d ? r1_we : r0_we;
                    address_d    = gnt_d ? r1_address : r0_address;
                    writedata_d  = gnt_d ? r1_writedata : r0_writedata;
                    chipselect_d = 1'b1;
                    write_n_d    = ~we_d;
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                // Slave readdata is combinational from the registered address; capture it now.
                if (!we_q) begin
                    if (gnt_q) begin
                        rd1_d = readdata;
                    end else begin
                        rd0_d = readdata;
                    end
                end
                ack0_d       = ~gnt_q;
                ack1_d       = gnt_q;
                last_grant_d = gnt_q;
                state_d      = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers, cleared asynchronously so an in-flight access is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            chipselect_q <= chipselect_d;
            write_n_q    <= write_n_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output mapping; busy is a decode of the state register.
    always_comb begin
        address     = address_q;
        writedata   = writedata_q;
        chipselect  = chipselect_q;
        write_n     = write_n_q;
        r0_ack      = ack0_q;
        r1_ack      = ack1_q;
        r0_readdata = rd0_q;
        r1_readdata = rd1_q;
        last_grant  = last_grant_q;
        busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Randomized scoreboard bench for pio_access_arbiter with a transaction-level arbitration model.
module tb_pio_access_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned NREG   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              req [2];
    logic              we [2];
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W-1:0] wd [2];
    logic              r0_ack, r1_ack;
    logic [DATA_W-1:0] r0_readdata, r1_readdata;
    logic [ADDR_W-1:0] address;
    logic              chipselect, write_n;
    logic [DATA_W-1:0] writedata, readdata;
    logic              busy, last_grant;

    pio_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .r0_req       (req[0]),
        .r0_we        (we[0]),
        .r0_address   (addr[0]),
        .r0_writedata (wd[0]),
        .r0_ack       (r0_ack),
        .r0_readdata  (r0_readdata),
        .r1_req       (req[1]),
        .r1_we        (we[1]),
        .r1_address   (addr[1]),
        .r1_writedata (wd[1]),
        .r1_ack       (r1_ack),
        .r1_readdata  (r1_readdata),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .busy         (busy),
        .last_grant   (last_grant)
    );

    always #5 clk = ~clk;

    // Slave register file: combinational read, write on chipselect with write_n low.
    logic [DATA_W-1:0] slave_mem [NREG];
    assign readdata = slave_mem[address];
    always @(posedge clk) begin
        if (chipselect && !write_n) slave_mem[address] <= writedata;
    end

    typedef struct {
        int                g;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;
    } exp_t;

    exp_t cs_q[$];
    exp_t ack_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: requester status 0=idle, 1=waiting, 2=in flight.
    int                st [2];
    int                m_wait;
    int                m_g;
    bit                m_last;
    logic [DATA_W-1:0] m_mem [NREG];
    logic [DATA_W-1:0] exp_rd [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; exp_rd[i] = '0; req[i] = 1'b0;
        end
        m_wait = 0;
        m_g    = 0;
        m_last = 1'b1;
    endtask

    task automatic new_req(input int i);
        req[i]  = 1'b1;
        we[i]   = 1'($urandom);
        addr[i] = ADDR_W'($urandom);
        wd[i]   = $urandom;
        st[i]   = 1;
    endtask

    // One cycle of stimulus, driven at the falling edge, plus the model's view of the next edge.
    task automatic drive_cycle(input bit allow_new, input bit force_tie);
        exp_t e;
        int   g;
        @(negedge clk);
        if (m_wait == 2) begin
            // Access in progress: the in-flight requester may scramble its inputs or drop req.
            we[m_g]   = 1'($urandom);
            addr[m_g] = ADDR_W'($urandom);
            wd[m_g]   = $urandom;
            if ($urandom_range(0, 3) == 0) req[m_g] = 1'b0;
        end else if (m_wait == 1) begin
            // Ack cycle: drop req, or keep it high as a fresh request.
            if (allow_new && $urandom_range(0, 2) == 0) new_req(m_g);
            else begin
                req[m_g] = 1'b0;
                st[m_g]  = 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (st[i] == 0) begin
                if (allow_new && (force_tie || $urandom_range(0, 2) == 0)) new_req(i);
                else begin
                    we[i] = 1'($urandom); addr[i] = ADDR_W'($urandom); wd[i] = $urandom;
                end
            end
        end
        if (m_wait == 0) begin
            if (st[0] == 1 || st[1] == 1) begin
                if (st[0] == 1 && st[1] == 1) g = m_last ? 0 : 1;
                else g = (st[1] == 1) ? 1 : 0;
                e.g = g; e.we = we[g]; e.addr = addr[g]; e.wd = wd[g];
                if (we[g]) m_mem[addr[g]] = wd[g];
                else exp_rd[g] = m_mem[addr[g]];
                e.rd0 = exp_rd[0];
                e.rd1 = exp_rd[1];
                cs_q.push_back(e);
                ack_q.push_back(e);
                st[g]  = 2;
                m_g    = g;
                m_last = (g == 1);
                m_wait = 2;
            end
        end else begin
            m_wait--;
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents chipselect or an ack.
    bit mon_en = 1'b0;
    bit prev_cs = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset_n) begin
            prev_cs = 1'b0;
        end else if (mon_en) begin
            if (chipselect) begin
                check("cs_single_cycle", 64'(prev_cs), 64'd0);
                if (cs_q.size() == 0) begin
                    check("cs_unexpected", 64'(chipselect), 64'd0);
                end else begin
                    e = cs_q.pop_front();
                    check("slave_address", 64'(address), 64'(e.addr));
                    check("slave_write_n", 64'(write_n), 64'(!e.we));
                    check("slave_writedata", 64'(writedata), 64'(e.wd));
                end
            end else begin
                check("write_n_idle", 64'(write_n), 64'd1);
            end
            if (r0_ack || r1_ack) begin
                check("ack_onehot", 64'(r0_ack && r1_ack), 64'd0);
                check("ack_after_cs", 64'(prev_cs), 64'd1);
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 64'(r0_ack || r1_ack), 64'd0);
                end else begin
                    e = ack_q.pop_front();
                    check("ack_index", 64'(r1_ack), 64'(e.g));
                    check("r0_readdata", 64'(r0_readdata), 64'(e.rd0));
                    check("r1_readdata", 64'(r1_readdata), 64'(e.rd1));
                    check("last_grant", 64'(last_grant), 64'(e.g));
                    check("busy_at_ack", 64'(busy), 64'd1);
                end
            end
            prev_cs = chipselect;
        end
    end

    task automatic run_random(input int ncycles);
        int guard;
        drive_cycle(1'b1, 1'b1);  // first arbitration after reset is a tie
        for (int c = 0; c < ncycles; c++) drive_cycle(1'b1, 1'b0);
        guard = 0;
        while ((st[0] != 0 || st[1] != 0 || m_wait != 0) && guard < 30) begin
            drive_cycle(1'b0, 1'b0);
            guard++;
        end
        check("drain_done", 64'(guard < 30), 64'd1);
        repeat (3) @(posedge clk);
        #2;
        check("cs_queue_empty", 64'(cs_q.size()), 64'd0);
        check("ack_queue_empty", 64'(ack_q.size()), 64'd0);
        check("busy_after_drain", 64'(busy), 64'd0);
        check("last_grant_final", 64'(last_grant), 64'(m_last));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_chipselect"}, 64'(chipselect), 64'd0);
        check({tag, "_write_n"}, 64'(write_n), 64'd1);
        check({tag, "_address"}, 64'(address), 64'd0);
        check({tag, "_writedata"}, 64'(writedata), 64'd0);
        check({tag, "_acks"}, 64'({r0_ack, r1_ack}), 64'd0);
        check({tag, "_r0_readdata"}, 64'(r0_readdata), 64'd0);
        check({tag, "_r1_readdata"}, 64'(r1_readdata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_last_grant"}, 64'(last_grant), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < int'(NREG); i++) begin
            slave_mem[i] = $urandom;
            m_mem[i]     = slave_mem[i];
        end
        for (int i = 0; i < 2; i++) begin
            we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
        model_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        run_random(300);

        // Reset in the middle of an access: no ack, outputs straight back to reset values.
        mon_en = 1'b0;
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 2'd1; wd[0] = 32'h77;
        req[1] = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cs_high", 64'(chipselect), 64'd1);
        check("abort_write_n_low", 64'(write_n), 64'd0);
        reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        req[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_no_ack", 64'({r0_ack, r1_ack}), 64'd0);
            check("abort_no_cs", 64'(chipselect), 64'd0);
        end
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        run_random(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
